// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise load/store has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MASK_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_wr,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [MASK_W-1:0] ls_wr_mask,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wr_mask,
  input  logic [DATA_W-1:0] mem_rdata
);

  // state   | meaning
  // IDLE    | grants possible; stores complete in the grant cycle
  // RD_WAIT | read outstanding; counter runs down to the rvalid cycle
  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

  localparam int CNT_W = $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_VAL = CNT_W'(READ_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             ls_win;
  logic             rd_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  logic rr_ptr_q;  // 1 = load/store wins the next tie

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b1;
    end else if (if_gnt || ls_gnt) begin
      rr_ptr_q <= if_gnt;
    end
  end

  assign ls_win = ls_req && (!if_req || rr_ptr_q);
`else
  assign ls_win = ls_req;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (ls_gnt && !ls_wr) begin
          state_d = RD_WAIT;
          cnt_d   = LAT_VAL;
          owner_d = 1'b1;
        end else if (if_gnt) begin
          state_d = RD_WAIT;
          cnt_d   = LAT_VAL;
          owner_d = 1'b0;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grants and rvalid are gated by rst_n so nothing leaks out while reset is held.
  always_comb begin
    if_gnt      = rst_n && (state_q == IDLE) && if_req && !ls_win;
    ls_gnt      = rst_n && (state_q == IDLE) && ls_win;
    rd_done     = rst_n && (state_q == RD_WAIT) && (cnt_q == CNT_ONE);
    if_rvalid   = rd_done && !owner_q;
    ls_rvalid   = rd_done && owner_q;
    mem_en      = if_gnt || ls_gnt;
    mem_wr      = ls_gnt && ls_wr;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wr_mask = '1;
    if (ls_gnt) begin
      mem_addr    = ls_addr;
      mem_wdata   = ls_wdata;
      mem_wr_mask = ls_wr_mask;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end
  end

  assign if_rdata = mem_rdata;
  assign ls_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a cycle-count model
// with a byte-lane BRAM stand-in; honours MEM_ARB_RR_EN in the same way as the design.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MW  = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req = 1'b0;
  logic          ls_wr = 1'b0;
  logic [AW-1:0] ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;
  logic [MW-1:0] ls_wr_mask = '1;
  logic          ls_gnt, ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          mem_en, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wr_mask;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .READ_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wr_mask(ls_wr_mask),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr_mask(mem_wr_mask), .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return (i == 64) ? 32'hDEAD_BEEF : ((32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000);
  endfunction

  // BRAM stand-in: byte-lane writes, reads appear LAT cycles after the access.
  logic [DW-1:0] ram  [0:255];
  logic [DW-1:0] pipe [0:LAT-1];
  logic          load_ram = 1'b1;
  assign mem_rdata = pipe[LAT-1];

  always @(posedge clk) begin
    if (load_ram) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else if (mem_en && mem_wr) begin
      for (int b = 0; b < 4; b++)
        if (!mem_wr_mask[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    pipe[0] <= (mem_en && !mem_wr) ? ram[mem_addr[9:2]] : 32'h0BAD_0BAD;
    for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle model %0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: the port is free from cycle free_at; one read response may be pending.
  logic [DW-1:0] shadow [0:255];
  int            cyc = 0;
  int            free_at = 0;
  bit            pend_v = 1'b0;
  int            pend_due = 0;
  bit            pend_ls = 1'b0;
  logic [DW-1:0] pend_data = '0;
  bit            fav_ls = 1'b1;
  bit            last_if = 1'b0;
  bit            last_ls = 1'b0;

  task automatic model_reset();
    pend_v  = 1'b0;
    free_at = 0;
    fav_ls  = 1'b1;
  endtask

  task automatic step();
    bit    e_if, e_ls, idle, rv;
    string tag;
    @(negedge clk);
    idle = rst_n && (cyc >= free_at);
    e_ls = idle && ls_req && (!if_req || fav_ls);
    e_if = idle && if_req && !e_ls;
    rv   = rst_n && pend_v && (pend_due == cyc);
    check_eq("if_gnt", 64'(if_gnt), 64'(e_if));
    check_eq("ls_gnt", 64'(ls_gnt), 64'(e_ls));
    check_eq("mem_en", 64'(mem_en), 64'(e_if || e_ls));
    check_eq("mem_wr", 64'(mem_wr), 64'(e_ls && ls_wr));
    check_eq("if_rvalid", 64'(if_rvalid), 64'(rv && !pend_ls));
    check_eq("ls_rvalid", 64'(ls_rvalid), 64'(rv && pend_ls));
    if (rv) begin
      tag = pend_ls ? "ls_rdata" : "if_rdata";
      check_eq(tag, 64'(pend_ls ? ls_rdata : if_rdata), 64'(pend_data));
    end
    if (e_ls) begin
      check_eq("ls_mem_addr", 64'(mem_addr), 64'(ls_addr));
      check_eq("ls_mem_mask", 64'(mem_wr_mask), 64'(ls_wr_mask));
      if (ls_wr) check_eq("ls_mem_wdata", 64'(mem_wdata), 64'(ls_wdata));
    end else if (e_if) begin
      check_eq("if_mem_addr", 64'(mem_addr), 64'(if_addr));
      check_eq("if_mem_mask", 64'(mem_wr_mask), 64'(16'hFFFF));
    end else if (idle && !if_req && !ls_req) begin
      check_eq("idle_mem_addr", 64'(mem_addr), 64'd0);
      check_eq("idle_mem_wdata", 64'(mem_wdata), 64'd0);
      check_eq("idle_mem_mask", 64'(mem_wr_mask), 64'(16'hFFFF));
    end
    @(posedge clk);
    #1;
    if (rv) pend_v = 1'b0;
`ifdef MEM_ARB_RR_EN
    if (e_if || e_ls) fav_ls = e_if;
`endif
    if (e_ls && ls_wr) begin
      for (int b = 0; b < 4; b++)
        if (!ls_wr_mask[b]) shadow[ls_addr[9:2]][8*b +: 8] = ls_wdata[8*b +: 8];
    end else if (e_if || e_ls) begin
      pend_v    = 1'b1;
      pend_due  = cyc + LAT;
      pend_ls   = e_ls;
      pend_data = shadow[e_ls ? ls_addr[9:2] : if_addr[9:2]];
      free_at   = cyc + LAT + 1;
    end
    last_if = e_if;
    last_ls = e_ls;
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);

    // Reset held with both requesters active: nothing may be granted.
    if_req = 1'b1; if_addr = 32'h100; ls_req = 1'b1; ls_addr = 32'h8;
    step();
    load_ram = 1'b0;
    step();
    rst_n = 1'b1; if_req = 1'b0; ls_req = 1'b0;
    step();

    // Single fetch of 0xDEADBEEF.
    if_req = 1'b1; if_addr = 32'h100;
    step();
    if_req = 1'b0;
    repeat (3) step();

    // Byte store, then a back-to-back store, then load the first word back.
    ls_req = 1'b1; ls_wr = 1'b1; ls_addr = 32'h204; ls_wdata = 32'hAB; ls_wr_mask = 16'hFFFE;
    step();
    ls_addr = 32'h208; ls_wdata = 32'h1234_5678; ls_wr_mask = 16'hFFF0;
    step();
    ls_wr = 1'b0; ls_addr = 32'h204;
    step();
    ls_req = 1'b0;
    repeat (3) step();

    // Reset asserted one cycle into a fetch read: the read must never return.
    if_req = 1'b1; if_addr = 32'h10;
    step();
    if_req = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1; if_req = 1'b1; if_addr = 32'h100;
    step();
    if_req = 1'b0;
    repeat (3) step();

    // Both requesters held through several reads, then load/store drops out.
    if_req = 1'b1; if_addr = 32'h40; ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h80;
    repeat (9) step();
    ls_req = 1'b0;
    repeat (4) step();
    if_req = 1'b0;
    repeat (3) step();

    // Random traffic; requesters hold request and payload until granted.
    for (int n = 0; n < 3000; n++) begin
      if (!if_req || last_if) begin
        if_req  = ($urandom_range(0, 99) < 50);
        if_addr = $urandom;
      end
      if (!ls_req || last_ls) begin
        ls_req     = ($urandom_range(0, 99) < 50);
        ls_wr      = 1'($urandom_range(0, 1));
        ls_addr    = $urandom;
        ls_wdata   = $urandom;
        ls_wr_mask = 16'($urandom);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous memory between the instruction-fetch path and the load/store path. The block grants one requester per access and drives the memory address, write data, write strobe and byte mask. It sequences the fixed read latency and returns read data to the requester that issued the read. It sits between the core's fetch and load/store logic and the unified BRAM, and stalls the losing requester by withholding its grant.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MASK_W`, default 16: write byte mask width. Active-low: mask bit i = 0 enables byte lane i.
- `READ_LAT`, default 1: memory read latency in cycles. Legal range 1..4.

Ports:
- `clk`  in  1: the single clock. All state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `if_req`  in  1: fetch read request.
- `if_addr`  in  ADDR_W: fetch address.
- `if_gnt`  out  1: fetch request accepted this cycle.
- `if_rvalid`  out  1: `if_rdata` valid this cycle.
- `if_rdata`  out  DATA_W: fetch read data.
- `ls_req`  in  1: load/store request.
- `ls_wr`  in  1: 1 = store, 0 = load.
- `ls_addr`  in  ADDR_W: load/store address.
- `ls_wdata`  in  DATA_W: store data.
- `ls_wr_mask`  in  MASK_W: store byte mask.
- `ls_gnt`  out  1: load/store request accepted this cycle.
- `ls_rvalid`  out  1: `ls_rdata` valid this cycle.
- `ls_rdata`  out  DATA_W: load read data.
- `mem_en`  out  1: memory access strobe.
- `mem_wr`  out  1: memory write strobe.
- `mem_addr`  out  ADDR_W: memory address.
- `mem_wdata`  out  DATA_W: memory write data.
- `mem_wr_mask`  out  MASK_W: memory byte mask.
- `mem_rdata`  in  DATA_W: memory read data, valid READ_LAT cycles after the `mem_en` read cycle.

## Operation
- FSM states:
  - IDLE: grants are possible.
  - RD_WAIT: a read is outstanding; no grants.
- Latency counter, `$clog2(READ_LAT+1)` bits wide.
- Owner register: 0 = fetch, 1 = load/store.
- In IDLE, a requester holding `req` high may be granted in the same cycle. `gnt`, `mem_*` and the grant decision are combinational from state and requests.
- Grant effects:
  - `mem_en` = 1 in the grant cycle.
  - `mem_addr` is taken from the winning requester.
  - For a load/store grant, `mem_wr` = `ls_wr` and `mem_wdata`/`mem_wr_mask` pass through from the load/store port.
  - For a fetch grant, `mem_wr` = 0 and `mem_wr_mask` = all ones.
- Store grant: completes in the grant cycle. State stays IDLE. No `rvalid` is produced. Back-to-back stores are accepted every cycle.
- Read grant (fetch or load): owner is latched, counter is loaded with READ_LAT, and the state moves to RD_WAIT.
- RD_WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 1, the owner's `rvalid` = 1 for exactly one cycle and the state returns to IDLE.
- `if_rdata` and `ls_rdata` pass `mem_rdata` through continuously; they are meaningful only while the matching `rvalid` is high.
- Requesters hold `req` and address/data stable until `gnt`. Requests arriving in RD_WAIT wait and are not lost.
- When no request is present in IDLE, all `mem_*` outputs are 0, except `mem_wr_mask`, which is all ones.
- Reset (asserted at any time, including mid-read):
  - State → IDLE, counter 0, owner 0, round-robin pointer 1.
  - All grants, `rvalid`s and `mem_en`/`mem_wr` are forced 0 while `rst_n` is low.
  - An outstanding read is discarded and never returns `rvalid`.

## Timing
- Read granted at cycle T: `rvalid` at T+READ_LAT; next grant possible at T+READ_LAT+1.
- Port occupancy: READ_LAT+1 cycles per read, 1 cycle per store.
- Simultaneous `if_req` and `ls_req` in IDLE: arbitration policy decides (see Configuration). Exactly one `gnt` asserts per cycle; never both.
- `rvalid` never asserts in a grant cycle.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - On a tie, the winner is the requester not granted most recently. The pointer updates on every grant.
  - Reset pointer favours load/store.
- `MEM_ARB_RR_EN` undefined: fixed priority. Load/store always wins a tie; fetch is granted only when `ls_req` = 0.

## Test plan
- Reset mid-read: READ_LAT=2, fetch read at T, `rst_n` low at T+1 → no `if_rvalid`. State IDLE after release; a new fetch request is granted on the first cycle after release.
- Single fetch: READ_LAT=2, `if_req`=1, `if_addr`=0x100, memory returns 0xDEADBEEF → `if_gnt` at T; `mem_en`=1, `mem_addr`=0x100 at T; `if_rvalid`=1 with `if_rdata`=0xDEADBEEF at T+2; no grant at T+1..T+2.
- Store byte: `ls_req`=1, `ls_wr`=1, `ls_addr`=0x204, `ls_wdata`=0xAB, mask=0xFFFE → `ls_gnt`, `mem_wr`=1, `mem_wr_mask`=0xFFFE in the same cycle; no `ls_rvalid`. A second store is granted the next cycle.
- Tie, priority build (macro undefined): both requests held for 3 reads, READ_LAT=1 → `ls_gnt` on all three grants; `if_gnt` only after `ls_req` drops.
- Tie, round-robin build (`MEM_ARB_RR_EN`): both requests held, READ_LAT=1 → grants alternate LS, IF, LS, IF at cycles 0, 2, 4, 6.
- Request during RD_WAIT: load outstanding with READ_LAT=3, `if_req` raised at T+1 → `if_gnt` no earlier than T+4; `ls_rvalid` at T+3 carries the load's data.
